argmax_scan_selector: RTL

Parametrised successor to the output-layer max selector. Captures a snapshot of N_CLASSES classifier scores via a valid/ready handshake and scans them serially, one channel per clock. Produces the winning class index and its score, with optional runner-up index and confidence margin. Sits between the final neuron layer and the result/display logic; adds signed-score support, deterministic tie-breaking and output backpressure.

---
 rtl/argmax_scan_selector.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/argmax_scan_selector.sv
// Serial argmax over a captured snapshot of N_CLASSES scores, one channel per clock.
// Define ARGMAX_RUNNER_UP_EN to add runner-up index and confidence-margin outputs.
module argmax_scan_selector #(
  parameter int N_CLASSES = 10,
  parameter int SCORE_W   = 26,
  parameter int SIGNED    = 0,
  localparam int IDX_W    = $clog2(N_CLASSES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_CLASSES*SCORE_W-1:0]   scores,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               img_num,
  output logic [SCORE_W-1:0]             max_score
`ifdef ARGMAX_RUNNER_UP_EN
  ,
  output logic [IDX_W-1:0]               second_num,
  output logic [SCORE_W:0]               margin
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [SCORE_W-1:0] snap [N_CLASSES];
  logic [IDX_W-1:0]   ptr_p0;
  logic [IDX_W-1:0]   best_idx_p0;
  logic [SCORE_W-1:0] best_val_p0;
  logic [IDX_W-1:0]   nxt_best_idx;
  logic [SCORE_W-1:0] nxt_best_val;
  logic [SCORE_W-1:0] ch;
  logic               accept;
  logic               last;

  function automatic logic gt(input logic [SCORE_W-1:0] a, input logic [SCORE_W-1:0] b);
    logic signed [SCORE_W-1:0] sa;
    logic signed [SCORE_W-1:0] sb;
    sa = a;
    sb = b;
    if (SIGNED != 0) gt = (sa > sb);
    else             gt = (a > b);
  endfunction

  assign ch     = snap[ptr_p0];
  assign accept = in_valid & in_ready;
  assign last   = (state == SCAN) && (ptr_p0 == IDX_W'(N_CLASSES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SCAN;
      SCAN:    if (last) state_nxt = DONE;
      DONE:    if (out_valid & out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are glitch-free outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

`ifdef ARGMAX_RUNNER_UP_EN
  logic [IDX_W-1:0]   sec_idx_p0;
  logic [SCORE_W-1:0] sec_val_p0;
  logic               sec_vld_p0;
  logic [IDX_W-1:0]   nxt_sec_idx;
  logic [SCORE_W-1:0] nxt_sec_val;
  logic               nxt_sec_vld;

  function automatic logic [SCORE_W:0] diff_ext(input logic [SCORE_W-1:0] a,
                                                input logic [SCORE_W-1:0] b);
    logic signed [SCORE_W:0] ea;
    logic signed [SCORE_W:0] eb;
    ea = {(SIGNED != 0) ? a[SCORE_W-1] : 1'b0, a};
    eb = {(SIGNED != 0) ? b[SCORE_W-1] : 1'b0, b};
    diff_ext = ea - eb;
  endfunction

  // A displaced best becomes the runner-up; equal scores fall through to the runner-up slot.
  always_comb begin
    nxt_best_idx = best_idx_p0;
    nxt_best_val = best_val_p0;
    nxt_sec_idx  = sec_idx_p0;
    nxt_sec_val  = sec_val_p0;
    nxt_sec_vld  = sec_vld_p0;
    if (gt(ch, best_val_p0)) begin
      nxt_sec_idx  = best_idx_p0;
      nxt_sec_val  = best_val_p0;
      nxt_sec_vld  = 1'b1;
      nxt_best_idx = ptr_p0;
      nxt_best_val = ch;
    end else if (!sec_vld_p0 || gt(ch, sec_val_p0)) begin
      nxt_sec_idx  = ptr_p0;
      nxt_sec_val  = ch;
      nxt_sec_vld  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sec_vld_p0 <= 1'b0;
    end else if (state == SCAN) begin
      sec_idx_p0 <= nxt_sec_idx;
      sec_val_p0 <= nxt_sec_val;
      sec_vld_p0 <= nxt_sec_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      second_num <= '0;
      margin     <= '0;
    end else if (last) begin
      second_num <= nxt_sec_idx;
      margin     <= diff_ext(nxt_best_val, nxt_sec_val);
    end
  end
`else
  always_comb begin
    nxt_best_idx = best_idx_p0;
    nxt_best_val = best_val_p0;
    if (gt(ch, best_val_p0)) begin
      nxt_best_idx = ptr_p0;
      nxt_best_val = ch;
    end
  end
`endif

  // ---- scan stage: snapshot capture and running best ----
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N_CLASSES; i++) begin
        snap[i] <= scores[i*SCORE_W +: SCORE_W];
      end
      best_idx_p0 <= '0;
      best_val_p0 <= scores[SCORE_W-1:0];
      ptr_p0      <= IDX_W'(1);
    end else if (state == SCAN) begin
      best_idx_p0 <= nxt_best_idx;
      best_val_p0 <= nxt_best_val;
      ptr_p0      <= ptr_p0 + 1'b1;
    end
  end

  // ---- result stage: outputs change only on DONE entry or reset ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      img_num   <= '0;
      max_score <= '0;
    end else if (last) begin
      img_num   <= nxt_best_idx;
      max_score <= nxt_best_val;
    end
  end

endmodule
